// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
//   dmem_state_t : responder FSM states (IDLE -> WAIT -> RESP -> IDLE)
//   BYTES        : byte lanes per word
//   ADDR_LSB     : lowest byte-address bit that forms the word index
//   CNT_W        : width of the latency counter (LATENCY up to 15)
//   addr_err()   : flags a misaligned or out-of-range word access
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int BYTES    = 4;
    localparam int ADDR_LSB = 2;
    localparam int CNT_W    = 4;

    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(depth));
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 32 single-port RAM with per-byte write enables and a
// registered read port. Contents are not reset.
//   clk   in   clock
//   en    in   access enable for this cycle
//   we    in   1 = write enabled lanes, 0 = read full word into rdata
//   be    in   byte-lane write enables (little-endian lanes)
//   addr  in   word index
//   wdata in   write data
//   rdata out  read data, updated only by a read access
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 we,
    input  logic [BYTES-1:0]     be,
    input  logic [AW-1:0]        addr,
    input  logic [BYTES*8-1:0]   wdata,
    output logic [BYTES*8-1:0]   rdata
);

    logic [BYTES*8-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (be[b]) begin
                        mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the core data port. Accepts one
// load/store at a time over valid/ready and returns read data or a write ack
// LATENCY cycles after the accept.
// Optional feature macro: DMEM_ERR_EN (misaligned / out-of-range access error).
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active-low
//   req_valid  in   request present
//   req_ready  out  responder idle and out of reset
//   req_we     in   1 = store, 0 = load
//   req_be     in   store byte enables
//   req_addr   in   byte address
//   req_wdata  in   store data
//   rsp_valid  out  response present
//   rsp_ready  in   core accepts response
//   rsp_rdata  out  load data (0 for stores / errors / no response)
//   rsp_err    out  access error (always 0 without DMEM_ERR_EN)
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [BYTES-1:0]      req_be,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int AW = $clog2(DEPTH);

    dmem_state_t           state, state_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic                  enter_resp;
    logic                  accept;
    logic                  rd_sel;

    // Captured request (data only, not reset)
    logic                  cap_we;
    logic [BYTES-1:0]      cap_be;
    logic [31:0]           cap_addr;
    logic [DATA_WIDTH-1:0] cap_wdata;

    // Access operands: with LATENCY==1 the access happens on the accept edge,
    // so the live request is used while in IDLE, the captured copy otherwise.
    logic                  acc_we;
    logic [BYTES-1:0]      acc_be;
    logic [31:0]           acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic                  acc_err;
    logic                  ram_en;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  unused_addr_bits;

    assign req_ready = (state == IDLE) && rst;
    assign accept    = req_ready && req_valid;
    assign rsp_valid = (state == RESP);

    assign acc_we    = (state == IDLE) ? req_we    : cap_we;
    assign acc_be    = (state == IDLE) ? req_be    : cap_be;
    assign acc_addr  = (state == IDLE) ? req_addr  : cap_addr;
    assign acc_wdata = (state == IDLE) ? req_wdata : cap_wdata;

    // Without error checking the upper address bits are dropped, so the word
    // index wraps modulo DEPTH and byte-offset bits are ignored.
    assign unused_addr_bits = ^{acc_addr[31:AW+ADDR_LSB], acc_addr[ADDR_LSB-1:0]};

`ifdef DMEM_ERR_EN
    logic err_q;

    assign acc_err = addr_err(acc_addr, DEPTH);
    assign rsp_err = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (enter_resp) begin
            err_q <= acc_err;
        end else if (rsp_valid && rsp_ready) begin
            err_q <= 1'b0;
        end
    end
`else
    assign acc_err = 1'b0;
    assign rsp_err = 1'b0;
`endif

    // Next-state / latency counter
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_d = CNT_W'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt - 1'b1;
                // Move on as the counter reaches zero, giving exactly LATENCY
                // cycles from accept to rsp_valid.
                if (cnt <= CNT_W'(1)) begin
                    cnt_d      = '0;
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            rd_sel <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (enter_resp) begin
                rd_sel <= !acc_we && !acc_err;
            end else if (rsp_valid && rsp_ready) begin
                rd_sel <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cap_we    <= req_we;
            cap_be    <= req_be;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
        end
    end

    // The RAM access is issued so that it completes on the edge entering RESP;
    // the RAM's read register then holds the load word for the whole response.
    assign ram_en = enter_resp && !acc_err;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (acc_we),
        .be    (acc_be),
        .addr  (acc_addr[ADDR_LSB +: AW]),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    assign rsp_rdata = rd_sel ? ram_rdata : '0;

endmodule
